// File: rtl/bias_activation.sv
// Element-serial bias add with signed saturation and selectable activation, fed by the matrix multiplier.
// One element per clock after a start accept; done follows ROWS*COLS cycles later; start ignored while busy.
module bias_activation #(
    parameter int                 ROWS        = 4,
    parameter int                 COLS        = 4,
    parameter int                 LEAKY_SHIFT = 3,
    parameter logic signed [31:0] CLAMP_MAX   = 32'sh0006_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         act_sel,
    input  logic signed [31:0] matrix_in [ROWS][COLS],
    input  logic signed [31:0] bias      [ROWS],
    output logic signed [31:0] result    [ROWS][COLS],
    output logic               busy,
    output logic               done,
    output logic               sat
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [RW-1:0]      row_q, row_d;
    logic [CW-1:0]      col_q, col_d;
    logic               sat_q, sat_d;
    logic [1:0]         act_q;
    logic signed [31:0] mat_q    [ROWS][COLS];
    logic signed [31:0] bias_q   [ROWS];
    logic signed [31:0] result_q [ROWS][COLS];

    logic               accept, wr;
    logic signed [31:0] x, b, y, act_v;
    logic [32:0]        s;
    logic               ovf;

    // Overflow shows up as disagreement between the two top bits of the 33-bit sum.
    always_comb begin
        x   = mat_q[row_q][col_q];
        b   = bias_q[row_q];
        s   = {x[31], x} + {b[31], b};
        ovf = s[32] ^ s[31];
        if (ovf) y = s[32] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
        else     y = s[31:0];
        act_v = y;
        case (act_q)
            2'd0: act_v = y;
            2'd1: act_v = y[31] ? 32'sd0 : y;
            2'd2: act_v = y[31] ? (y >>> LEAKY_SHIFT) : y;
            2'd3: act_v = y[31] ? 32'sd0 : ((y > CLAMP_MAX) ? CLAMP_MAX : y);
            default: act_v = y;
        endcase
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        sat_d   = sat_q;
        accept  = 1'b0;
        wr      = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = S_RUN;
                    row_d   = '0;
                    col_d   = '0;
                    sat_d   = 1'b0;
                end
            end
            S_RUN: begin
                wr = 1'b1;
                if (ovf) sat_d = 1'b1;
                if (col_q == COL_LAST) begin
                    col_d = '0;
                    if (row_q == ROW_LAST) state_d = S_DONE;
                    else                   row_d   = row_q + RW'(1);
                end else begin
                    col_d = col_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            sat_q   <= 1'b0;
            act_q   <= 2'd0;
            for (int r = 0; r < ROWS; r++) begin
                bias_q[r] <= '0;
                for (int c = 0; c < COLS; c++) begin
                    mat_q[r][c]    <= '0;
                    result_q[r][c] <= '0;
                end
            end
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            sat_q   <= sat_d;
            if (accept) begin
                act_q <= act_sel;
                for (int r = 0; r < ROWS; r++) begin
                    bias_q[r] <= bias[r];
                    for (int c = 0; c < COLS; c++) begin
                        mat_q[r][c]    <= matrix_in[r][c];
                        result_q[r][c] <= '0;
                    end
                end
            end else if (wr) begin
                result_q[row_q][col_q] <= act_v;
            end
        end
    end

    assign result = result_q;
    assign busy   = (state_q == S_RUN);
    assign done   = (state_q == S_DONE);
    assign sat    = sat_q;

endmodule
